alarm_controller: RTL and testbench

- Top-level alarm-system state machine that sequences the passcode entry block. It owns system_state and the passcode entry-window timer that the passcode block consumes.
- Handles arming (exit delay), sensor trip (entry delay), siren, and disarm on passcode_correct.
- Sits between the board I/O (arm button, door sensor, LEDs, 7-seg) and the passcode block.

---
 rtl/alarm_controller_pkg.sv | 15 +
 rtl/alarm_controller_if.sv | 24 ++
 rtl/alarm_controller_sec_downcounter.sv | 51 +++++
 rtl/alarm_controller.sv | 155 +++++++++++++++
 tb/tb_alarm_controller.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/alarm_controller_pkg.sv
// Shared types and constants for the alarm controller and its passcode block.
package alarm_controller_pkg;

  typedef enum logic [2:0] {
    STATE_IDLE    = 3'd0,
    STATE_ARMING  = 3'd1,
    STATE_SET     = 3'd2,
    STATE_TRIGGER = 3'd3,
    STATE_ALARM   = 3'd4
  } fsm_state_t;

  // Passcode block state value meaning "no digits accepted yet".
  localparam logic [2:0] PC_IDLE = 3'd0;

endpackage

// File: rtl/alarm_controller_if.sv
// Link between the alarm controller (master) and the passcode block (slave).
interface alarm_controller_if;
  import alarm_controller_pkg::*;

  logic       passcode_correct;
  logic [2:0] passcode_state;
  fsm_state_t system_state;
  logic [7:0] timer;

  modport master (
    input  passcode_correct,
    input  passcode_state,
    output system_state,
    output timer
  );

  modport slave (
    output passcode_correct,
    output passcode_state,
    input  system_state,
    input  timer
  );

endinterface

// File: rtl/alarm_controller_sec_downcounter.sv
// Seconds down-counter: a CLK_HZ prescaler feeding an 8-bit saturating
// counter. expire flags the tick on which the count leaves 1.
module sec_downcounter #(
  parameter int         CLK_HZ    = 50_000_000,
  parameter logic [7:0] RESET_VAL = 8'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       en,
  output logic [7:0] count,
  output logic       expire
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc_r;
  logic [7:0]    count_r;
  logic          tick_s;

  assign tick_s = en && (presc_r == PRESC_MAX);
  assign count  = count_r;
  assign expire = tick_s && (count_r == 8'd1);

  // Prescaler and seconds count; load restarts the second boundary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_r <= '0;
      count_r <= RESET_VAL;
    end else if (load) begin
      presc_r <= '0;
      count_r <= load_val;
    end else if (tick_s) begin
      presc_r <= '0;
      if (count_r != 8'd0) begin
        count_r <= count_r - 8'd1;
      end else begin
        count_r <= 8'd0;
      end
    end else if (en) begin
      presc_r <= presc_r + PW'(1);
      count_r <= count_r;
    end else begin
      presc_r <= presc_r;
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm-system sequencer: arming exit delay, sensor entry delay, siren with
// auto-rearm, disarm on a correct passcode, and the passcode entry timer.
module alarm_controller
  import alarm_controller_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int EXIT_S  = 10,
  parameter int ENTRY_S = 15,
  parameter int ALARM_S = 60,
  parameter int DIGIT_S = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arm_btn_n,
  input  logic                      sensor,
  output logic [7:0]                countdown,
  output logic                      siren,
  output logic                      armed_led,
  alarm_controller_if.master        bus
);

  localparam logic [7:0] DIGIT_V = 8'(DIGIT_S);

  fsm_state_t state_r;
  fsm_state_t state_next_s;
  logic       btn_r;
  logic       btn_prev_r;
  logic       arm_pulse_s;
  logic       sensor_meta_r;
  logic       sensor_sync_r;
  logic [2:0] pc_prev_r;
  logic       siren_r;
  logic       armed_led_r;
  logic       phase_load_s;
  logic [7:0] phase_len_s;
  logic       phase_expire_s;
  logic       timer_load_s;
  logic [7:0] timer_s;

  // Duration in seconds of each timed phase; untimed states read 0.
  function automatic logic [7:0] phase_len(input fsm_state_t s);
    case (s)
      STATE_ARMING:  phase_len = 8'(EXIT_S);
      STATE_TRIGGER: phase_len = 8'(ENTRY_S);
      STATE_ALARM:   phase_len = 8'(ALARM_S);
      default:       phase_len = 8'd0;
    endcase
  endfunction

  // Register the inverted button, keep its previous value for edge detection,
  // and pass the asynchronous sensor through two flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_r         <= 1'b0;
      btn_prev_r    <= 1'b0;
      sensor_meta_r <= 1'b0;
      sensor_sync_r <= 1'b0;
      pc_prev_r     <= PC_IDLE;
    end else begin
      btn_r         <= ~arm_btn_n;
      btn_prev_r    <= btn_r;
      sensor_meta_r <= sensor;
      sensor_sync_r <= sensor_meta_r;
      pc_prev_r     <= bus.passcode_state;
    end
  end

  assign arm_pulse_s = btn_r & ~btn_prev_r;

  // Next-state decision; a correct passcode outranks sensor and expiry.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      STATE_IDLE: begin
        if (arm_pulse_s) state_next_s = STATE_ARMING;
        else             state_next_s = STATE_IDLE;
      end
      STATE_ARMING: begin
        if (arm_pulse_s)         state_next_s = STATE_IDLE;
        else if (phase_expire_s) state_next_s = STATE_SET;
        else                     state_next_s = STATE_ARMING;
      end
      STATE_SET: begin
        if (bus.passcode_correct) state_next_s = STATE_IDLE;
        else if (sensor_sync_r)   state_next_s = STATE_TRIGGER;
        else                      state_next_s = STATE_SET;
      end
      STATE_TRIGGER: begin
        if (bus.passcode_correct) state_next_s = STATE_IDLE;
        else if (phase_expire_s)  state_next_s = STATE_ALARM;
        else                      state_next_s = STATE_TRIGGER;
      end
      STATE_ALARM: begin
        if (phase_expire_s) state_next_s = STATE_SET;
        else                state_next_s = STATE_ALARM;
      end
      default: state_next_s = STATE_IDLE;
    endcase
  end

  // State register plus Moore outputs registered alongside it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= STATE_IDLE;
      siren_r     <= 1'b0;
      armed_led_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      siren_r     <= (state_next_s == STATE_ALARM);
      armed_led_r <= (state_next_s == STATE_SET) ||
                     (state_next_s == STATE_TRIGGER) ||
                     (state_next_s == STATE_ALARM);
    end
  end

  // Any state change reloads the phase counter with the new phase length.
  assign phase_load_s = (state_next_s != state_r);
  assign phase_len_s  = phase_len(state_next_s);

  sec_downcounter #(
    .CLK_HZ    (CLK_HZ),
    .RESET_VAL (8'd0)
  ) u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (phase_load_s),
    .load_val (phase_len_s),
    .en       (1'b1),
    .count    (countdown),
    .expire   (phase_expire_s)
  );

  // Entry window restarts whenever the passcode block is idle or advances.
  assign timer_load_s = (bus.passcode_state == PC_IDLE) ||
                        (bus.passcode_state != pc_prev_r);

  sec_downcounter #(
    .CLK_HZ    (CLK_HZ),
    .RESET_VAL (DIGIT_V)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load_s),
    .load_val (DIGIT_V),
    .en       (1'b1),
    .count    (timer_s),
    .expire   ()
  );

  assign bus.system_state = state_r;
  assign bus.timer        = timer_s;
  assign siren            = siren_r;
  assign armed_led        = armed_led_r;

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with CLK_HZ=4, EXIT_S=2, ENTRY_S=3,
// ALARM_S=2, DIGIT_S=2. Inputs change and outputs are sampled 1 ns after
// each rising edge.
module tb_alarm_controller;
  import alarm_controller_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       arm_btn_n;
  logic       sensor;
  logic [7:0] countdown;
  logic       siren;
  logic       armed_led;
  int         checks;
  int         failures;

  alarm_controller_if bus ();

  alarm_controller #(
    .CLK_HZ  (4),
    .EXIT_S  (2),
    .ENTRY_S (3),
    .ALARM_S (2),
    .DIGIT_S (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arm_btn_n (arm_btn_n),
    .sensor    (sensor),
    .countdown (countdown),
    .siren     (siren),
    .armed_led (armed_led),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Step until the state matches, bounded; the final compare doubles as timeout check.
  task automatic wait_state(input string tag, input fsm_state_t target, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (bus.system_state == target) break;
      step(1);
    end
    check(tag, 32'(bus.system_state), 32'(target));
  endtask

  task automatic arm_to_arming(input string tag);
    arm_btn_n = 1'b0;
    step(1);
    wait_state(tag, STATE_ARMING, 6);
    arm_btn_n = 1'b1;
  endtask

  initial begin
    int trig_seen;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    arm_btn_n = 1'b1;
    sensor   = 1'b0;
    bus.passcode_correct = 1'b0;
    bus.passcode_state   = 3'd0;
    step(2);
    check("rst_state", 32'(bus.system_state), 32'(STATE_IDLE));
    check("rst_countdown", 32'(countdown), 32'd0);
    check("rst_timer", 32'(bus.timer), 32'd2);
    check("rst_siren", 32'(siren), 32'd0);
    check("rst_armed", 32'(armed_led), 32'd0);
    rst_n = 1'b1;
    step(2);

    // 1: arming exit delay of 2 s = 8 cycles
    arm_to_arming("t1_arming");
    check("t1_cd_entry", 32'(countdown), 32'd2);
    check("t1_armed_arming", 32'(armed_led), 32'd0);
    step(7);
    check("t1_still_arming", 32'(bus.system_state), 32'(STATE_ARMING));
    check("t1_cd_last", 32'(countdown), 32'd1);
    step(1);
    check("t1_set", 32'(bus.system_state), 32'(STATE_SET));
    check("t1_armed_set", 32'(armed_led), 32'd1);
    check("t1_cd_set", 32'(countdown), 32'd0);

    // 2: trip, entry delay 12 cycles, alarm 8 cycles, rearm
    sensor = 1'b1;
    step(1);
    wait_state("t2_trigger", STATE_TRIGGER, 5);
    sensor = 1'b0;
    check("t2_cd_entry", 32'(countdown), 32'd3);
    step(11);
    check("t2_still_trig", 32'(bus.system_state), 32'(STATE_TRIGGER));
    check("t2_cd_last", 32'(countdown), 32'd1);
    step(1);
    check("t2_alarm", 32'(bus.system_state), 32'(STATE_ALARM));
    check("t2_siren_on", 32'(siren), 32'd1);
    check("t2_cd_alarm", 32'(countdown), 32'd2);
    step(7);
    check("t2_still_alarm", 32'(bus.system_state), 32'(STATE_ALARM));
    step(1);
    check("t2_rearm", 32'(bus.system_state), 32'(STATE_SET));
    check("t2_siren_off", 32'(siren), 32'd0);
    check("t2_armed", 32'(armed_led), 32'd1);

    // 3: passcode on the final entry tick beats expiry
    sensor = 1'b1;
    step(1);
    wait_state("t3_trigger", STATE_TRIGGER, 5);
    sensor = 1'b0;
    step(11);
    check("t3_pre", 32'(bus.system_state), 32'(STATE_TRIGGER));
    bus.passcode_correct = 1'b1;
    step(1);
    bus.passcode_correct = 1'b0;
    check("t3_idle", 32'(bus.system_state), 32'(STATE_IDLE));
    check("t3_armed", 32'(armed_led), 32'd0);
    check("t3_siren", 32'(siren), 32'd0);
    check("t3_cd", 32'(countdown), 32'd0);
    step(2);

    // 4: sensor and passcode together in SET
    arm_to_arming("t4_arming");
    step(8);
    check("t4_set", 32'(bus.system_state), 32'(STATE_SET));
    sensor = 1'b1;
    bus.passcode_correct = 1'b1;
    trig_seen = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (bus.system_state == STATE_TRIGGER) trig_seen++;
    end
    check("t4_idle", 32'(bus.system_state), 32'(STATE_IDLE));
    check("t4_no_trigger", 32'(trig_seen), 32'd0);
    sensor = 1'b0;
    bus.passcode_correct = 1'b0;
    step(2);

    // 5: entry-window timer
    bus.passcode_state = 3'd1;
    step(1);
    check("t5_load", 32'(bus.timer), 32'd2);
    step(3);
    check("t5_hold", 32'(bus.timer), 32'd2);
    step(1);
    check("t5_dec1", 32'(bus.timer), 32'd1);
    step(1);
    bus.passcode_state = 3'd2;
    step(1);
    check("t5_reload", 32'(bus.timer), 32'd2);
    step(4);
    check("t5_dec2", 32'(bus.timer), 32'd1);
    step(4);
    check("t5_zero", 32'(bus.timer), 32'd0);
    step(4);
    check("t5_sat", 32'(bus.timer), 32'd0);
    bus.passcode_state = 3'd0;
    step(1);
    check("t5_idle_hold", 32'(bus.timer), 32'd2);
    step(2);

    // 6: cancel during arming, then reset during trigger
    arm_to_arming("t6_arming");
    step(2);
    arm_btn_n = 1'b0;
    step(1);
    wait_state("t6_cancel", STATE_IDLE, 6);
    check("t6_cancel_cd", 32'(countdown), 32'd0);
    arm_btn_n = 1'b1;
    step(2);
    arm_to_arming("t6_rearming");
    step(8);
    check("t6_set", 32'(bus.system_state), 32'(STATE_SET));
    sensor = 1'b1;
    step(1);
    wait_state("t6_trigger", STATE_TRIGGER, 5);
    sensor = 1'b0;
    bus.passcode_state = 3'd1;
    step(5);
    check("t6_timer_run", 32'(bus.timer), 32'd1);
    rst_n = 1'b0;
    step(1);
    check("t6_rst_state", 32'(bus.system_state), 32'(STATE_IDLE));
    check("t6_rst_cd", 32'(countdown), 32'd0);
    check("t6_rst_timer", 32'(bus.timer), 32'd2);
    check("t6_rst_siren", 32'(siren), 32'd0);
    check("t6_rst_armed", 32'(armed_led), 32'd0);
    rst_n = 1'b1;
    bus.passcode_state = 3'd0;
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
